// File: rtl/riscv_defs_pkg.sv
// Definitions shared between the core and the byte-serial memory controller:
// access size codes, controller state encoding and the start of the I/O window.
package riscv_defs;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [17:0] IO_BASE = 18'h30000;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_READ  = 2'd1,
        MC_WRITE = 2'd2
    } mc_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } mc_port_e;

    // Index of the final byte of an access; code 3 is treated as a word.
    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (size)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests and
// turns each one into little-endian byte cycles on the 8-bit RAM/IO bus.
module mem_ctrl
    import riscv_defs::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    mc_state_e         state_q, state_d;
    mc_port_e          port_q, port_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        iss_q, iss_d;
    logic [1:0]        rcv_q, rcv_d;
    logic              iss_on_q, iss_on_d;
    logic              infl_q, infl_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [7:0]        dout_q, dout_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic [1:0]        nxt_idx;
    logic              take_ls;
    logic              take_if;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= MC_IDLE;
            port_q     <= PORT_IF;
            base_q     <= '0;
            addr_q     <= '0;
            last_q     <= 2'd0;
            iss_q      <= 2'd0;
            rcv_q      <= 2'd0;
            iss_on_q   <= 1'b0;
            infl_q     <= 1'b0;
            buf_q      <= 32'd0;
            wdata_q    <= 32'd0;
            wr_q       <= 1'b0;
            dout_q     <= 8'd0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            iss_q      <= iss_d;
            rcv_q      <= rcv_d;
            iss_on_q   <= iss_on_d;
            infl_q     <= infl_d;
            buf_q      <= buf_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            dout_q     <= dout_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // A port whose done pulse is showing still holds its request for that
    // cycle, so it is masked out of arbitration until the requester drops it.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        base_d     = base_q;
        addr_d     = addr_q;
        last_d     = last_q;
        iss_d      = iss_q;
        rcv_d      = rcv_q;
        iss_on_d   = iss_on_q;
        infl_d     = infl_q;
        buf_d      = buf_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        dout_d     = dout_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        nxt_idx    = iss_q + 2'd1;
        take_ls    = ls_req && !ls_done_q;
        take_if    = if_req && !if_done_q;

        if (!rdy_in) begin
            // A paused read cycle may have lost its byte: restart issue at the
            // first byte not yet received.
            if (state_q == MC_READ) begin
                iss_d    = rcv_q;
                addr_d   = base_q + ADDR_W'(rcv_q);
                iss_on_d = 1'b1;
                infl_d   = 1'b0;
            end
        end else begin
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            case (state_q)
                MC_IDLE: begin
                    if (take_ls) begin
                        port_d = PORT_LS;
                        base_d = ls_addr;
                        addr_d = ls_addr;
                        last_d = size_last(ls_size);
                        iss_d  = 2'd0;
                        rcv_d  = 2'd0;
                        buf_d  = 32'd0;
                        if (ls_we) begin
                            state_d = MC_WRITE;
                            wdata_d = ls_wdata;
                            wr_d    = 1'b1;
                            dout_d  = ls_wdata[7:0];
                        end else begin
                            state_d  = MC_READ;
                            iss_on_d = 1'b1;
                            infl_d   = 1'b0;
                        end
                    end else if (take_if) begin
                        port_d   = PORT_IF;
                        base_d   = if_addr;
                        addr_d   = if_addr;
                        last_d   = size_last(SZ_W);
                        iss_d    = 2'd0;
                        rcv_d    = 2'd0;
                        buf_d    = 32'd0;
                        state_d  = MC_READ;
                        iss_on_d = 1'b1;
                        infl_d   = 1'b0;
                    end
                end

                MC_WRITE: begin
                    if (iss_q == last_q) begin
                        state_d   = MC_IDLE;
                        wr_d      = 1'b0;
                        ls_done_d = 1'b1;
                    end else begin
                        iss_d  = nxt_idx;
                        addr_d = base_q + ADDR_W'(nxt_idx);
                        dout_d = wdata_q[{nxt_idx, 3'b000} +: 8];
                    end
                end

                MC_READ: begin
                    if (iss_on_q) begin
                        infl_d = 1'b1;
                        if (iss_q == last_q) begin
                            iss_on_d = 1'b0;
                        end else begin
                            iss_d  = nxt_idx;
                            addr_d = base_q + ADDR_W'(nxt_idx);
                        end
                    end else begin
                        infl_d = 1'b0;
                    end
                    if (infl_q) begin
                        buf_d[{rcv_q, 3'b000} +: 8] = mem_din;
                        rcv_d = rcv_q + 2'd1;
                        if (rcv_q == last_q) begin
                            state_d  = MC_IDLE;
                            infl_d   = 1'b0;
                            iss_on_d = 1'b0;
                            if (port_q == PORT_LS) begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = buf_d;
                            end else begin
                                if_done_d = 1'b1;
                                if_data_d = buf_d;
                            end
                        end
                    end
                end

                default: state_d = MC_IDLE;
            endcase
        end
    end

    assign mem_a    = addr_q;
    assign mem_dout = dout_q;
    assign mem_wr   = wr_q & rdy_in;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised bench for mem_ctrl: a RAM model on the bus plus a separate
// reference memory that tracks what every completed store should have left behind.
module tb_mem_ctrl;
    import riscv_defs::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  bus_mem [0:262143];
    logic [7:0]  ref_mem [0:262143];

    int          check_count = 0;
    int          error_count = 0;
    logic [31:0] exp_if_data = 32'd0;
    logic [31:0] exp_ls_rdata = 32'd0;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_size  (ls_size),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr)
    );

    // Synchronous-read RAM: the byte addressed in one cycle appears the next.
    always @(posedge clk_in) begin
        mem_din <= bus_mem[mem_a[17:0]];
        if (mem_wr) bus_mem[mem_a[17:0]] <= mem_dout;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
    endfunction

    task automatic setBoth(input logic [17:0] a, input logic [7:0] v);
        bus_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Runs one access starting in cycle 0 (called just after a rising edge).
    // pause_mask bit k drives rdy_in low during cycle k.
    task automatic applyStimulus(input bit is_ls, input bit we_in, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [15:0] pause_mask, input string tag);
        int          n;
        int          active;
        int          exp_done;
        int          done_cycle;
        bit          we;
        bit          seen;
        bit          read_paused;
        logic [15:0] pm;
        logic [31:0] exp_data;
        logic [31:0] obs_data;
        logic [31:0] a_i;
        logic [31:0] wr_addr_q[$];
        logic [7:0]  wr_byte_q[$];
        logic [31:0] rd_addr_q[$];

        checkOutput({tag, ".hold_if_data"}, if_data, exp_if_data);
        checkOutput({tag, ".hold_ls_rdata"}, ls_rdata, exp_ls_rdata);

        we = is_ls && we_in;
        n  = is_ls ? nbytes(size) : 4;
        pm = pause_mask & 16'hFFFE;
        exp_data = 32'd0;
        for (int i = 0; i < n; i++) begin
            a_i = addr + 32'(i);
            exp_data[8*i +: 8] = ref_mem[a_i[17:0]];
        end
        // A store needs n active write cycles followed by an active done cycle.
        active   = 0;
        exp_done = -1;
        for (int k = 1; k < 16; k++) begin
            if (!pm[k]) begin
                active++;
                if (active == n + 1 && exp_done < 0) exp_done = k;
            end
        end
        read_paused = 1'b0;
        for (int k = 1; k <= n + 2; k++) if (pm[k]) read_paused = 1'b1;

        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end

        seen = 1'b0;
        done_cycle = -1;
        obs_data = 32'd0;
        for (int k = 0; k < 40 && !seen; k++) begin
            rdy_in = (k < 16) ? !pm[k] : 1'b1;
            @(negedge clk_in);
            if (mem_wr) begin
                wr_addr_q.push_back(mem_a);
                wr_byte_q.push_back(mem_dout);
            end
            if (rdy_in && k >= 1 && k <= n) rd_addr_q.push_back(mem_a);
            if (rdy_in && (is_ls ? ls_done : if_done)) begin
                seen = 1'b1;
                done_cycle = k;
                obs_data = is_ls ? ls_rdata : if_data;
            end
            @(posedge clk_in);
            #1;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        rdy_in = 1'b1;

        checkOutput({tag, ".done_seen"}, 32'(seen), 32'd1);
        if (!seen) return;

        if (we) begin
            checkOutput({tag, ".st_latency"}, done_cycle, exp_done);
            checkOutput({tag, ".wr_count"}, wr_addr_q.size(), n);
            for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
                checkOutput({tag, ".wr_addr"}, wr_addr_q[i], addr + 32'(i));
                checkOutput({tag, ".wr_byte"}, 32'(wr_byte_q[i]), 32'(wdata[8*i +: 8]));
            end
            for (int i = 0; i < n; i++) begin
                a_i = addr + 32'(i);
                ref_mem[a_i[17:0]] = wdata[8*i +: 8];
            end
        end else begin
            checkOutput({tag, ".rd_data"}, obs_data, exp_data);
            checkOutput({tag, ".rd_no_write"}, wr_addr_q.size(), 0);
            if (is_ls) exp_ls_rdata = exp_data;
            else       exp_if_data  = exp_data;
            if (read_paused) begin
                checkOutput({tag, ".rd_delayed"}, 32'(done_cycle > n + 2), 32'd1);
            end else begin
                checkOutput({tag, ".rd_latency"}, done_cycle, n + 2);
                for (int i = 0; i < n && i < rd_addr_q.size(); i++)
                    checkOutput({tag, ".rd_addr"}, rd_addr_q[i], addr + 32'(i));
            end
        end
    endtask

    initial begin : main
        int          done_cnt;
        int          wr_cnt;
        int          ls_cycle;
        int          if_cycle;
        bit          drop_ls;
        bit          drop_if;
        logic [31:0] v;
        bit          is_ls;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [15:0] pm;

        for (int i = 0; i < 262144; i++) begin
            v = $urandom;
            bus_mem[i] = v[7:0];
            ref_mem[i] = v[7:0];
        end

        rst_in = 1'b1; rdy_in = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        #3;
        checkOutput("reset.mem_a", mem_a, 32'd0);
        checkOutput("reset.mem_wr", 32'(mem_wr), 32'd0);
        checkOutput("reset.mem_dout", 32'(mem_dout), 32'd0);
        checkOutput("reset.done", {30'd0, if_done, ls_done}, 32'd0);
        checkOutput("reset.if_data", if_data, 32'd0);
        checkOutput("reset.ls_rdata", ls_rdata, 32'd0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;

        done_cnt = 0;
        wr_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (if_done || ls_done) done_cnt++;
            if (mem_wr) wr_cnt++;
        end
        checkOutput("idle.done_pulses", done_cnt, 0);
        checkOutput("idle.mem_wr", wr_cnt, 0);
        checkOutput("idle.mem_a", mem_a, 32'd0);
        @(posedge clk_in);
        #1;

        setBoth(18'h100, 8'h13); setBoth(18'h101, 8'h05);
        setBoth(18'h102, 8'hA0); setBoth(18'h103, 8'h00);
        applyStimulus(1'b0, 1'b0, SZ_W, 32'h100, 32'd0, 16'h0, "if_word");
        checkOutput("if_word.value", if_data, 32'h00A00513);

        applyStimulus(1'b1, 1'b1, SZ_B, 32'h30000, 32'h41, 16'h0, "st_byte_io");

        // Both ports request together; load/store must win and finish first.
        setBoth(18'h203, 8'hFF); setBoth(18'h204, 8'h80);
        setBoth(18'h400, 8'h11); setBoth(18'h401, 8'h22);
        setBoth(18'h402, 8'h33); setBoth(18'h403, 8'h44);
        if_req = 1'b1; if_addr = 32'h400;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = SZ_H; ls_addr = 32'h203;
        ls_cycle = -1; if_cycle = -1;
        for (int k = 0; k < 60 && (ls_cycle < 0 || if_cycle < 0); k++) begin
            drop_ls = 1'b0; drop_if = 1'b0;
            @(negedge clk_in);
            if (ls_done && ls_cycle < 0) begin
                ls_cycle = k; drop_ls = 1'b1;
                checkOutput("arb.ls_rdata", ls_rdata, 32'h000080FF);
                checkOutput("arb.if_pending", 32'(if_cycle >= 0), 32'd0);
            end
            if (if_done && if_cycle < 0) begin
                if_cycle = k; drop_if = 1'b1;
                checkOutput("arb.if_data", if_data, 32'h44332211);
            end
            @(posedge clk_in);
            #1;
            if (drop_ls) ls_req = 1'b0;
            if (drop_if) if_req = 1'b0;
        end
        ls_req = 1'b0; if_req = 1'b0;
        checkOutput("arb.ls_latency", ls_cycle, 4);
        checkOutput("arb.if_after_ls", 32'(if_cycle > ls_cycle), 32'd1);
        exp_ls_rdata = 32'h000080FF;
        exp_if_data  = 32'h44332211;

        applyStimulus(1'b1, 1'b1, SZ_W, 32'h500, 32'hCAFEBABE, 16'h0004, "st_pause");
        applyStimulus(1'b1, 1'b0, SZ_W, 32'h500, 32'd0, 16'h0008, "ld_pause");
        checkOutput("ld_pause.value", ls_rdata, 32'hCAFEBABE);

        applyStimulus(1'b1, 1'b0, SZ_W, 32'hFFFF_FFFE, 32'd0, 16'h0, "ld_wrap");
        applyStimulus(1'b1, 1'b1, SZ_H, 32'hFFFF_FFFF, 32'h0000A55A, 16'h0, "st_wrap");
        applyStimulus(1'b1, 1'b0, SZ_H, 32'hFFFF_FFFF, 32'd0, 16'h0, "ld_wrap_back");
        applyStimulus(1'b1, 1'b0, 2'd3, 32'h601, 32'd0, 16'h0, "ld_size3");

        // Asynchronous reset in the middle of a word load.
        ls_req = 1'b1; ls_we = 1'b0; ls_size = SZ_W; ls_addr = 32'h700;
        repeat (3) begin
            @(posedge clk_in);
            #1;
        end
        #2 rst_in = 1'b1;
        #1;
        checkOutput("rst_mid.mem_a", mem_a, 32'd0);
        checkOutput("rst_mid.mem_wr", 32'(mem_wr), 32'd0);
        checkOutput("rst_mid.done", {30'd0, if_done, ls_done}, 32'd0);
        checkOutput("rst_mid.ls_rdata", ls_rdata, 32'd0);
        checkOutput("rst_mid.if_data", if_data, 32'd0);
        exp_ls_rdata = 32'd0;
        exp_if_data  = 32'd0;
        ls_req = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in);
            if (if_done || ls_done) done_cnt++;
            if (k == 2) rst_in = 1'b0;
        end
        checkOutput("rst_mid.no_done", done_cnt, 0);
        @(posedge clk_in);
        #1;
        applyStimulus(1'b1, 1'b0, SZ_W, 32'h700, 32'd0, 16'h0, "after_rst");

        for (int t = 0; t < 150; t++) begin
            is_ls = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 1) == 1) ? (32'h1000 + 32'($urandom_range(0, 63)))
                                                 : 32'($urandom_range(0, 32'h2FFF0));
            pm    = ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'h00FE) : 16'h0;
            applyStimulus(is_ls, we, size, addr, $urandom, pm, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
